gray_arb: RTL
=============

# gray_arb

Two-requester round-robin controller for the shared 3-bit Gray counter (`gray`: Clk, Reset, En, Output[2:0], Overflow). Each requester asks for a burst of N counter steps. The block grants the counter to one requester at a time and drives its En for exactly N cycles. It then returns the final Gray code and an overflow flag to the winner. It sits between the requesters and the single counter instance; it owns the counter's En, and nothing else drives it.

## Interface
- Parameters: none (widths are fixed by the counter).
- Clk  in  1  rising-edge clock, shared with the counter
- Reset  in  1  synchronous, active-high
- Req  in  2  level request per requester, bit i = requester i
- Len0  in  4  step count for requester 0, sampled only at acceptance
- Len1  in  4  step count for requester 1, sampled only at acceptance
- GrayIn  in  3  counter Output
- OvfIn  in  1  counter Overflow
- En  out  1  counter enable, registered
- Gnt  out  2  one-hot grant, registered
- Busy  out  1  high in RUN or DONE
- Done  out  2  one-cycle completion pulse to the winner
- Result  out  3  GrayIn captured at completion, held until the next completion
- Ovf  out  1  OvfIn was seen high during the burst; held like Result
- Aborted  out  1  burst ended early; held like Result (0 when the macro is off)

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE, all outputs 0, remaining count 0, priority pointer = requester 0.
- IDLE with Req != 0: select the winner.
  - If only one bit is set, that requester wins.
  - If both bits are set, the requester named by the priority pointer wins.
  - Latch the winner's Len into a 4-bit remaining count.
  - Move the pointer to the other requester.
  - Next state: RUN if Len != 0, else DONE.
- RUN: En=1 every cycle. Remaining count decrements by 1 each cycle. The cycle in which it equals 1 is the last RUN cycle; next state DONE.
- DONE: En=0. Sample GrayIn into Result. Next state IDLE.
- Done[w]=1 for exactly the one cycle after DONE.
- Gnt[w] and Busy are high in every RUN and DONE cycle and low in IDLE.
- Ovf is set if OvfIn=1 in any RUN or DONE cycle of the burst. It is cleared at acceptance of the next burst.
- Len=0: no En cycles. Done still pulses and Result = current GrayIn.
- Req held high through the Done cycle counts as a new request. The pointer already favours the other requester, so back-to-back requests alternate.
- Req changes during RUN or DONE are ignored. Len changes after acceptance are ignored.
- Reset mid-burst: return to IDLE on the next edge. En drops immediately, no Done is issued, and the burst is lost.

## Timing
- Acceptance edge to first En=1: 1 cycle.
- En is high for exactly Len consecutive cycles (1-15).
- Acceptance to Done pulse: Len+2 cycles.
- Result reflects all Len steps, because the counter updates on the edge ending the last RUN cycle and DONE samples after it.
- New acceptance is possible in the Done cycle. Minimum spacing between grants is Len+2 cycles.

## Configuration
- `GRAY_ARB_OVF_ABORT_EN` defined:
  - OvfIn=1 in any RUN cycle forces next state DONE.
  - En is 0 from the next cycle onward; remaining steps are discarded.
  - Aborted=1 and Ovf=1 with that Done.
  - OvfIn=1 in the last RUN cycle completes normally, with Aborted=0.
- `GRAY_ARB_OVF_ABORT_EN` undefined: overflow never shortens a burst, and Aborted is tied to 0.

## Test plan
The bench ties the arbiter to a real `gray` instance, with the counter reset to 000 before each case. Counter sequence: 000, 001, 011, 010, 110, 111, 101, 100, wrap to 000.
- Req=01, Len0=3:
  - En high for 3 cycles.
  - Done=01 five cycles after acceptance.
  - Result=010, Ovf=0, Gnt=01 only during RUN and DONE.
- Req=11 held, Len0=2, Len1=1 → grants alternate 01, 10, 01. Done pulses alternate, with no idle cycle between Done and the next acceptance.
- Req=10, Len1=0 → no En pulse. Done=10 two cycles after acceptance; Result=000.
- Req=01, Len0=9, macro off → 9 En cycles, Result=001, Ovf=1, Aborted=0.
- Same stimulus, macro on → En stops after the wrap cycle. Aborted=1, Ovf=1, fewer than 9 En cycles.
- Reset during the 2nd RUN cycle of Len0=5 → next cycle has En=0, Gnt=00, Busy=0. No Done is issued, and the pointer is back to requester 0.

Source files
------------

// File: rtl/gray_arb.sv
// Round-robin arbiter for two requesters sharing one 3-bit Gray counter: grants the counter and drives its En for Len steps.
// Optional early termination on counter overflow is enabled by defining GRAY_ARB_OVF_ABORT_EN.
module gray_arb (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Req,
  input  logic [3:0] Len0,
  input  logic [3:0] Len1,
  input  logic [2:0] GrayIn,
  input  logic       OvfIn,
  output logic       En,
  output logic [1:0] Gnt,
  output logic       Busy,
  output logic [1:0] Done,
  output logic [2:0] Result,
  output logic       Ovf,
  output logic       Aborted
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [3:0] remain;
  logic       ptr;
  logic       win;
  logic       ovf_seen;
  logic       abort_seen;

  logic       pick;
  logic [3:0] len_sel;
  logic       stop_early;

  always_comb begin
    pick       = (Req == 2'b11) ? ptr : Req[1];
    len_sel    = pick ? Len1 : Len0;
    stop_early = 1'b0;
`ifdef GRAY_ARB_OVF_ABORT_EN
    // Overflow on the final step is a normal finish, not an abort.
    stop_early = OvfIn && (remain != 4'd1);
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      remain     <= '0;
      ptr        <= 1'b0;
      win        <= 1'b0;
      ovf_seen   <= 1'b0;
      abort_seen <= 1'b0;
      En         <= 1'b0;
      Gnt        <= '0;
      Busy       <= 1'b0;
      Done       <= '0;
      Result     <= '0;
      Ovf        <= 1'b0;
      Aborted    <= 1'b0;
    end else begin
      Done <= '0;
      case (state)
        IDLE: begin
          if (Req != 2'b00) begin
            win        <= pick;
            ptr        <= ~pick;
            remain     <= len_sel;
            ovf_seen   <= 1'b0;
            abort_seen <= 1'b0;
            Gnt        <= pick ? 2'b10 : 2'b01;
            Busy       <= 1'b1;
            if (len_sel != 4'd0) begin
              state <= RUN;
              En    <= 1'b1;
            end else begin
              state <= DONE;
              En    <= 1'b0;
            end
          end
        end
        RUN: begin
          remain   <= remain - 4'd1;
          ovf_seen <= ovf_seen | OvfIn;
          if ((remain == 4'd1) || stop_early) begin
            state      <= DONE;
            En         <= 1'b0;
            abort_seen <= stop_early;
          end
        end
        DONE: begin
          // Counter has taken its last step on the previous edge, so GrayIn is final here.
          state   <= IDLE;
          En      <= 1'b0;
          Gnt     <= '0;
          Busy    <= 1'b0;
          Done    <= win ? 2'b10 : 2'b01;
          Result  <= GrayIn;
          Ovf     <= ovf_seen | OvfIn;
          Aborted <= abort_seen;
        end
        default: begin
          state <= IDLE;
          En    <= 1'b0;
          Gnt   <= '0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
